// File: rtl/pio_word_resp_pkg.sv
// pio_word_resp_pkg
//   Shared definitions for the HPS PIO word-read responder:
//   FSM state type, hps_read_status bit positions and default widths.
package pio_word_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SERVE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // hps_read_status bit map
  localparam int ACK_B    = 0;  // ack, mirrors hps_read_clk[0] of last served request
  localparam int VALID_B  = 1;  // last served word was real data
  localparam int EMPTY_B  = 2;  // live fifo_empty
  localparam int ACTIVE_B = 3;  // session open
  localparam int ERR_B    = 4;  // sticky underflow / overrun error
  localparam int SEQ_LSB  = 5;  // 3-bit sequence count, bits [7:5]
  localparam int SEQ_W    = 3;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_STAT_W = 8;

endpackage

// File: rtl/pio_ctrl_sync.sv
// pio_ctrl_sync
//   Conditions the HPS control PIO bits and detects request toggles.
//   Build option: PIO_WORD_RESP_SYNC_EN adds a two-flop synchronizer on
//   both bits (two cycles of extra latency) for PIOs on a foreign clock.
// Ports:
//   clk      in  fabric clock
//   reset_n  in  synchronous active-low reset
//   rq_in    in  raw hps_read_rq[0]
//   clk_in   in  raw hps_read_clk[0]
//   rq_lvl   out conditioned session-open level
//   clk_lvl  out conditioned request-toggle level
//   clk_edge out one-cycle flag: clk_lvl differs from last cycle
module pio_ctrl_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic rq_in,
  input  logic clk_in,
  output logic rq_lvl,
  output logic clk_lvl,
  output logic clk_edge
);

  logic hist;

`ifdef PIO_WORD_RESP_SYNC_EN
  logic [1:0] rq_s;
  logic [1:0] clk_s;

  // The toggle chain is preloaded with the live level during reset so the
  // first cycle out of reset cannot report a spurious edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rq_s  <= '0;
      clk_s <= {2{clk_in}};
    end else begin
      rq_s  <= {rq_s[0], rq_in};
      clk_s <= {clk_s[0], clk_in};
    end
  end

  assign rq_lvl  = rq_s[1];
  assign clk_lvl = clk_s[1];
`else
  assign rq_lvl  = rq_in;
  assign clk_lvl = clk_in;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hist <= clk_in;
    end else begin
      hist <= clk_lvl;
    end
  end

  assign clk_edge = clk_lvl ^ hist;

endmodule

// File: rtl/pio_word_responder.sv
// pio_word_responder
//   Answers HPS PIO word-read requests from a show-ahead FIFO: each toggle of
//   hps_read_clk[0] during an open session (hps_read_rq[0]=1) pops one word
//   onto hps_word16, then the ack bit of hps_read_status follows the toggle.
//   Build option: PIO_WORD_RESP_SYNC_EN (see pio_ctrl_sync) adds input
//   synchronizers and two cycles of latency.
// Ports:
//   clk_clk          in  fabric clock
//   reset_reset_n    in  synchronous active-low reset
//   hps_read_rq      in  bit0 = session open
//   hps_read_clk     in  bit0 toggles once per requested word
//   fifo_q           in  FIFO head word (valid when !fifo_empty)
//   fifo_empty       in  FIFO empty flag
//   fifo_rdreq       out one-cycle pop strobe
//   hps_word16       out word returned to the HPS
//   hps_read_status  out {seq[2:0], err, active, empty, valid, ack}
module pio_word_responder
  import pio_word_resp_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [CTRL_W-1:0] hps_read_rq,
  input  logic [CTRL_W-1:0] hps_read_clk,
  input  logic [WORD_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic [WORD_W-1:0] hps_word16,
  output logic [STAT_W-1:0] hps_read_status
);

  logic             rq_lvl;
  logic             clk_lvl;
  logic             clk_edge;
  logic             ctrl_unused;

  state_t           state;
  logic             pend;
  logic             pend_lvl;
  logic             req_lvl;
  logic             ack;
  logic             valid;
  logic             active;
  logic             err;
  logic             run;
  logic [SEQ_W-1:0] seq;
  logic [WORD_W-1:0] word;
  logic [7:0]       status8;

  assign ctrl_unused = ^{hps_read_rq[CTRL_W-1:1], hps_read_clk[CTRL_W-1:1]};

  pio_ctrl_sync u_ctrl (
    .clk      (clk_clk),
    .reset_n  (reset_reset_n),
    .rq_in    (hps_read_rq[0]),
    .clk_in   (hps_read_clk[0]),
    .rq_lvl   (rq_lvl),
    .clk_lvl  (clk_lvl),
    .clk_edge (clk_edge)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state    <= ST_IDLE;
      pend     <= 1'b0;
      pend_lvl <= 1'b0;
      req_lvl  <= 1'b0;
      ack      <= 1'b0;
      valid    <= 1'b0;
      active   <= 1'b0;
      err      <= 1'b0;
      run      <= 1'b0;
      seq      <= '0;
      word     <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rq_lvl) begin
            state  <= ST_ARMED;
            err    <= 1'b0;
            seq    <= '0;
            ack    <= clk_lvl;
            active <= 1'b1;
            pend   <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (!rq_lvl) begin
            state  <= ST_IDLE;
            active <= 1'b0;
            pend   <= 1'b0;
          end else if (clk_edge) begin
            state   <= ST_SERVE;
            req_lvl <= clk_lvl;
          end
        end

        ST_SERVE: begin
          if (!fifo_empty) begin
            word  <= fifo_q;
            valid <= 1'b1;
          end else begin
            valid <= 1'b0;
            err   <= 1'b1;
          end
          seq <= seq + 1'b1;
          if (clk_edge) begin
            if (pend) begin
              err <= 1'b1;
            end else begin
              pend     <= 1'b1;
              pend_lvl <= clk_lvl;
            end
          end
          state <= ST_ACK;
        end

        ST_ACK: begin
          ack  <= req_lvl;
          pend <= 1'b0;
          if (pend && clk_edge) begin
            err <= 1'b1;
          end
          // An edge landing in this very cycle counts as pending: it is
          // taken directly rather than parked, so ARMED never has to look
          // at the pending flag. A dropped session discards it.
          if (rq_lvl && (pend || clk_edge)) begin
            state   <= ST_SERVE;
            req_lvl <= pend ? pend_lvl : clk_lvl;
          end else begin
            state <= ST_ARMED;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fifo_rdreq = (state == ST_SERVE) && !fifo_empty;
  assign hps_word16 = word;

  // empty is live, but held at 0 for the first cycle after reset so the
  // whole status byte reads 0 straight out of reset
  always_comb begin
    status8                    = '0;
    status8[ACK_B]             = ack;
    status8[VALID_B]           = valid;
    status8[EMPTY_B]           = fifo_empty & run;
    status8[ACTIVE_B]          = active;
    status8[ERR_B]             = err;
    status8[SEQ_LSB +: SEQ_W]  = seq;
  end

  assign hps_read_status = STAT_W'(status8);

endmodule
